// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the 24-bit single-issue CPU: opcode map,
// ALU operation classes and the main-decoder control word layout.
package cpu_pkg;

    localparam logic [3:0] OP_RTYPE     = 4'b0000;
    localparam logic [3:0] OP_RTYPE_ALT = 4'b0110;
    localparam logic [3:0] OP_ADDI      = 4'b0001;
    localparam logic [3:0] OP_LOAD      = 4'b0010;
    localparam logic [3:0] OP_STORE     = 4'b0011;
    localparam logic [3:0] OP_BEQ       = 4'b0100;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // Field order matches the decode map: RegDst first, Illegal last.
    typedef struct packed {
        logic       regDst;
        logic       aluSrc;
        logic       memToReg;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic [1:0] aluOp;
        logic       branch;
        logic       illegal;
    } ctrl_word_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode-to-control-word decoder. Unmapped opcodes (and any
// unknown value) fall into the default branch and become a flagged NOP.
module control_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opCode,
    output ctrl_word_t ctrlWord
);

    // Decode the opcode; every field starts at 0 so don't-cares are never X.
    always_comb begin
        ctrlWord = '0;
        case (opCode)
            OP_RTYPE, OP_RTYPE_ALT: begin
                ctrlWord.regDst   = 1'b1;
                ctrlWord.regWrite = 1'b1;
                ctrlWord.aluOp    = ALUOP_FUNCT;
            end
            OP_ADDI: begin
                ctrlWord.aluSrc   = 1'b1;
                ctrlWord.regWrite = 1'b1;
                ctrlWord.aluOp    = ALUOP_ADD;
            end
            OP_LOAD: begin
                ctrlWord.aluSrc   = 1'b1;
                ctrlWord.memToReg = 1'b1;
                ctrlWord.regWrite = 1'b1;
                ctrlWord.memRead  = 1'b1;
                ctrlWord.aluOp    = ALUOP_ADD;
            end
            OP_STORE: begin
                ctrlWord.aluSrc   = 1'b1;
                ctrlWord.memWrite = 1'b1;
                ctrlWord.aluOp    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrlWord.aluOp    = ALUOP_SUB;
                ctrlWord.branch   = 1'b1;
            end
            default: begin
                ctrlWord.illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Main decoder of the CPU. Decodes OPcode and registers the control word so
// it lines up with the following stage (one cycle latency).
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] OPcode,
    output logic       RegDst,
    output logic       ALUsrc,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] ALUop,
    output logic       Branch,
    output logic       Illegal
);

    ctrl_word_t decodedWord;
    ctrl_word_t ctrlReg;

    control_decode uDecode (
        .opCode   (OPcode),
        .ctrlWord (decodedWord)
    );

    // Register the decoded word; synchronous reset clears it to all zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrlReg <= '0;
        end else begin
            ctrlReg <= decodedWord;
        end
    end

    assign RegDst   = ctrlReg.regDst;
    assign ALUsrc   = ctrlReg.aluSrc;
    assign MemToReg = ctrlReg.memToReg;
    assign RegWrite = ctrlReg.regWrite;
    assign MemRead  = ctrlReg.memRead;
    assign MemWrite = ctrlReg.memWrite;
    assign ALUop    = ctrlReg.aluOp;
    assign Branch   = ctrlReg.branch;
    assign Illegal  = ctrlReg.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed and randomised checks of control_unit against a hand-written
// table of expected control words.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic [3:0] opCode;
    logic       regDst, aluSrc, memToReg, regWrite, memRead, memWrite;
    logic [1:0] aluOp;
    logic       branch, illegal;

    int unsigned vecCount;
    int unsigned missCount;

    control_unit dut (
        .clk      (clk),
        .reset    (reset),
        .OPcode   (opCode),
        .RegDst   (regDst),
        .ALUsrc   (aluSrc),
        .MemToReg (memToReg),
        .RegWrite (regWrite),
        .MemRead  (memRead),
        .MemWrite (memWrite),
        .ALUop    (aluOp),
        .Branch   (branch),
        .Illegal  (illegal)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word order: RegDst ALUsrc MemToReg RegWrite MemRead MemWrite ALUop[1:0] Branch Illegal
    localparam logic [9:0] W_R     = 10'b1_0_0_1_0_0_10_0_0;
    localparam logic [9:0] W_ADDI  = 10'b0_1_0_1_0_0_00_0_0;
    localparam logic [9:0] W_LOAD  = 10'b0_1_1_1_1_0_00_0_0;
    localparam logic [9:0] W_STORE = 10'b0_1_0_0_0_1_00_0_0;
    localparam logic [9:0] W_BEQ   = 10'b0_0_0_0_0_0_01_1_0;
    localparam logic [9:0] W_ILL   = 10'b0_0_0_0_0_0_00_0_1;

    function automatic logic [9:0] expWord(input logic [3:0] op);
        case (op)
            4'd0, 4'd6: return W_R;
            4'd1:       return W_ADDI;
            4'd2:       return W_LOAD;
            4'd3:       return W_STORE;
            4'd4:       return W_BEQ;
            default:    return W_ILL;
        endcase
    endfunction

    function automatic logic [9:0] obsWord();
        return {regDst, aluSrc, memToReg, regWrite, memRead, memWrite, aluOp, branch, illegal};
    endfunction

    task automatic checkVec(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, and settle past the edge before sampling.
    task automatic step(input logic rst, input logic [3:0] op);
        reset  = rst;
        opCode = op;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seqOps [5];
    logic [9:0] seqExp [5];

    initial begin
        logic [3:0] rop;
        logic       rrst;
        logic [9:0] want;
        vecCount  = 0;
        missCount = 0;
        reset     = 1'b1;
        opCode    = 4'b0010;
        #2;

        // Reset held for two edges with a load opcode present.
        step(1'b1, 4'b0010);
        checkVec("reset_edge1", obsWord(), 10'b0);
        step(1'b1, 4'b0010);
        checkVec("reset_edge2", obsWord(), 10'b0);
        step(1'b0, 4'b0010);
        checkVec("post_reset_load", obsWord(), W_LOAD);

        // Back-to-back opcodes, each word one cycle after its opcode.
        seqOps = '{4'b0110, 4'b0001, 4'b0010, 4'b0011, 4'b0000};
        seqExp = '{W_R, W_ADDI, W_LOAD, W_STORE, W_R};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, seqOps[i]);
            checkVec($sformatf("seq_%0d", i), obsWord(), seqExp[i]);
        end

        step(1'b0, 4'b0100);
        checkVec("beq", obsWord(), W_BEQ);

        // Every opcode outside the decode map must decode as a flagged NOP.
        for (int i = 5; i < 16; i++) begin
            if (i != 6) begin
                step(1'b0, 4'(i));
                checkVec($sformatf("illegal_%0d", i), obsWord(), W_ILL);
            end
        end

        // Reset asserted mid-stream clears the word at the next edge.
        step(1'b0, 4'b0000);
        checkVec("pre_midreset", obsWord(), W_R);
        step(1'b1, 4'b0001);
        checkVec("midreset", obsWord(), 10'b0);

        // Random opcodes with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            rop  = 4'($urandom_range(0, 15));
            rrst = ($urandom_range(0, 9) == 0);
            want = rrst ? 10'b0 : expWord(rop);
            step(rrst, rop);
            checkVec("rand_word", obsWord(), want);
            checkVec("rand_rd_wr", {9'b0, memRead & memWrite}, 10'b0);
            checkVec("rand_rw_wr", {9'b0, regWrite & memWrite}, 10'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
